// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// master = requester/memory side, slave = arbiter side.
interface data_mem_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          req0_valid;
    logic          req0_write;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req0_ready;
    logic          req0_done;
    logic [DW-1:0] req0_rdata;

    logic          req1_valid;
    logic          req1_write;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          req1_ready;
    logic          req1_done;
    logic [DW-1:0] req1_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, req0_done, req0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, req1_done, req1_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, req0_done, req0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, req1_done, req1_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port data memory.
// One access every 3 cycles, so the memory never sees both strobes at once.
//
// state | meaning
// IDLE  | waiting for a request; grant and latch on the accepting edge
// ISSUE | strobe the memory for the latched access (memory acts on the negedge)
// RESP  | pulse done and present read data to the latched port
module data_mem_arbiter #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 32
) (
    input  logic              Clk,
    input  logic              reset,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arbState_t;

    arbState_t     stateQ;
    arbState_t     stateNext;

    logic          rrLast;
    logic          portQ;
    logic          wrQ;
    logic [AW-1:0] addrQ;
    logic [DW-1:0] wdataQ;
    logic [DW-1:0] rdataQ;

    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          inRange;
    logic          ready0;
    logic          ready1;
    logic          done0;
    logic          done1;
    logic          memRead;
    logic          memWrite;

    assign inRange = addrQ < AW'(DEPTH);

    // On a tie the port that did not win last time goes first.
    assign grant0 = bus.req0_valid & (~bus.req1_valid | rrLast);
    assign grant1 = bus.req1_valid & (~bus.req0_valid | ~rrLast);
    assign accept = (stateQ == IDLE) & (grant0 | grant1);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateNext;
        end
    end

    // Strobes and done decode from state alone, so an async reset drops them at once.
    always_comb begin
        stateNext = stateQ;
        ready0    = 1'b0;
        ready1    = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        case (stateQ)
            IDLE: begin
                ready0 = grant0;
                ready1 = grant1;
                if (grant0 | grant1) begin
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                memWrite  = wrQ & inRange;
                memRead   = ~wrQ & inRange;
                stateNext = RESP;
            end
            RESP: begin
                done0     = ~portQ;
                done1     = portQ;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            rrLast <= 1'b1;
            portQ  <= 1'b0;
            wrQ    <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            rdataQ <= '0;
        end else begin
            if (accept) begin
                portQ  <= grant1;
                rrLast <= grant1;
                wrQ    <= grant1 ? bus.req1_write : bus.req0_write;
                addrQ  <= grant1 ? bus.req1_addr  : bus.req0_addr;
                wdataQ <= grant1 ? bus.req1_wdata : bus.req0_wdata;
            end
            // Writes and out-of-range reads return zero.
            if (stateQ == ISSUE) begin
                rdataQ <= memRead ? bus.mem_rdata : '0;
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.req0_done  = done0;
    assign bus.req1_done  = done1;
    assign bus.req0_rdata = done0 ? rdataQ : '0;
    assign bus.req1_rdata = done1 ? rdataQ : '0;

    assign bus.mem_addr   = addrQ;
    assign bus.mem_wdata  = wdataQ;
    assign bus.mem_read   = memRead;
    assign bus.mem_write  = memWrite;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: drivers push expected completions,
// a negedge monitor pops and compares them when a done pulse appears.
module tb_data_mem_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 32;

    logic Clk = 1'b0;
    logic reset = 1'b1;
    always #5 Clk = ~Clk;

    data_mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    data_mem_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .Clk  (Clk),
        .reset(reset),
        .bus  (bus)
    );

    int nCompared = 0;
    int nMismatch = 0;
    int cyc       = 0;
    int issueCyc  = -10;
    int nAccepted = 0;
    int nDone     = 0;
    int nAborted  = 0;

    typedef struct {
        bit            port;
        logic [DW-1:0] rdata;
        int            doneCyc;
    } exp_t;
    exp_t expQ[$];

    logic [DW-1:0] mem [DEPTH];

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Memory model: acts on the negedge, reads come back on mem_rdata.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + i;
        bus.mem_rdata = '0;
    end
    always @(negedge Clk) begin
        if (bus.mem_write && bus.mem_addr < DEPTH) mem[bus.mem_addr[4:0]] = bus.mem_wdata;
        if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr[4:0]];
    end

    // Monitor
    always @(negedge Clk) begin
        if (!reset) begin
            if (bus.mem_read | bus.mem_write) begin
                check("strobe_excl", 64'(bus.mem_read & bus.mem_write), 64'd0);
                check("strobe_cycle", 64'(cyc), 64'(issueCyc));
            end
            if (bus.req0_done | bus.req1_done) begin
                nDone++;
                check("done_onehot", 64'(bus.req0_done & bus.req1_done), 64'd0);
                if (expQ.size() == 0) begin
                    nCompared++;
                    nMismatch++;
                    $display("FAIL unexpected_done: got done0=%0b done1=%0b, required none (cycle %0d)",
                             bus.req0_done, bus.req1_done, cyc);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    check("done_port", 64'(bus.req1_done), 64'(e.port));
                    check("done_rdata", 64'(bus.req1_done ? bus.req1_rdata : bus.req0_rdata), 64'(e.rdata));
                    check("done_cycle", 64'(cyc), 64'(e.doneCyc));
                end
            end
        end
    end

    task automatic setReq(input bit port, input bit v, input bit wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port) begin
            bus.req1_valid = v; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
        end else begin
            bus.req0_valid = v; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
        end
    endtask

    // k = cycle index sampled in the accepting IDLE cycle
    task automatic pushExp(input bit port, input logic [DW-1:0] rd, input int k);
        exp_t e;
        e.port    = port;
        e.rdata   = rd;
        e.doneCyc = k + 2;
        expQ.push_back(e);
        nAccepted++;
        issueCyc = k + 1;
    endtask

    // Returns at posedge+1 of the ISSUE cycle, with valid dropped.
    task automatic issue(input bit port, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] expRd);
        int k;
        k = -1;
        @(negedge Clk);
        setReq(port, 1'b1, wr, a, d);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (port ? bus.req1_ready : bus.req0_ready) begin
                k = cyc;
                break;
            end
            @(negedge Clk);
        end
        if (k < 0) begin
            nCompared++;
            nMismatch++;
            $display("FAIL accept_timeout: port %0d got no ready, required ready within 20 cycles", port);
        end else begin
            pushExp(port, expRd, k);
        end
        @(posedge Clk);
        #1;
        setReq(port, 1'b0, 1'b0, a, d);
    endtask

    task automatic toIdle();
        repeat (2) @(posedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        int lastK;
        int doneBefore;
        int k;

        setReq(1'b0, 1'b0, 1'b0, '0, '0);
        setReq(1'b1, 1'b0, 1'b0, '0, '0);

        // Reset state
        repeat (2) @(negedge Clk);
        #1;
        check("rst_ready0", 64'(bus.req0_ready), 64'd0);
        check("rst_ready1", 64'(bus.req1_ready), 64'd0);
        check("rst_done0", 64'(bus.req0_done), 64'd0);
        check("rst_done1", 64'(bus.req1_done), 64'd0);
        check("rst_mem_read", 64'(bus.mem_read), 64'd0);
        check("rst_mem_write", 64'(bus.mem_write), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        @(negedge Clk);
        reset = 1'b0;

        // 1: write then read back through port 0
        issue(1'b0, 1'b1, 32'd5, 32'h666, 32'h0);
        check("t1_issue_write", 64'(bus.mem_write), 64'd1);
        check("t1_issue_read", 64'(bus.mem_read), 64'd0);
        check("t1_issue_addr", 64'(bus.mem_addr), 64'd5);
        check("t1_issue_wdata", 64'(bus.mem_wdata), 64'h666);
        @(posedge Clk);
        #1;
        check("t1_resp_write", 64'(bus.mem_write), 64'd0);
        check("t1_resp_addr_held", 64'(bus.mem_addr), 64'd5);
        @(posedge Clk);
        issue(1'b0, 1'b0, 32'd5, 32'h0, 32'h666);
        check("t1_read_strobe", 64'(bus.mem_read), 64'd1);
        toIdle();

        // 2: both ports valid continuously after reset -> 0,1,0,1 three cycles apart
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        setReq(1'b0, 1'b1, 1'b0, 32'd7, '0);
        setReq(1'b1, 1'b1, 1'b0, 32'd12, '0);
        grants = 0;
        lastK  = 0;
        for (int i = 0; i < 20 && grants < 4; i++) begin
            #1;
            if (bus.req0_ready | bus.req1_ready) begin
                check("t2_ready_onehot", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
                check("t2_grant_port", 64'(bus.req1_ready), 64'(grants % 2));
                if (grants > 0) check("t2_grant_gap", 64'(cyc - lastK), 64'd3);
                pushExp(bus.req1_ready, bus.req1_ready ? 32'hA000_000C : 32'hA000_0007, cyc);
                lastK = cyc;
                grants++;
            end
            if (grants < 4) @(negedge Clk);
        end
        check("t2_grant_count", 64'(grants), 64'd4);
        @(posedge Clk);
        #1;
        setReq(1'b0, 1'b0, 1'b0, '0, '0);
        setReq(1'b1, 1'b0, 1'b0, '0, '0);
        toIdle();

        // 3: out-of-range and boundary addresses
        issue(1'b1, 1'b0, 32'd40, 32'h0, 32'h0);
        check("t3_oor_read_strobe", 64'(bus.mem_read), 64'd0);
        check("t3_oor_write_strobe", 64'(bus.mem_write), 64'd0);
        toIdle();
        issue(1'b1, 1'b1, 32'd32, 32'hDEAD, 32'h0);
        check("t3_oor_wr_strobe", 64'(bus.mem_write), 64'd0);
        toIdle();
        issue(1'b0, 1'b0, 32'd31, 32'h0, 32'hA000_001F);
        check("t3_last_word_read", 64'(bus.mem_read), 64'd1);
        toIdle();

        // 4: port 1 arrives during port 0's ISSUE -> held until IDLE
        issue(1'b0, 1'b0, 32'd3, 32'h0, 32'hA000_0003);
        setReq(1'b1, 1'b1, 1'b0, 32'd20, '0);
        @(negedge Clk);
        #1;
        check("t4_ready1_issue", 64'(bus.req1_ready), 64'd0);
        @(negedge Clk);
        #1;
        check("t4_ready1_resp", 64'(bus.req1_ready), 64'd0);
        @(negedge Clk);
        #1;
        check("t4_ready1_idle", 64'(bus.req1_ready), 64'd1);
        if (bus.req1_ready) pushExp(1'b1, 32'hA000_0014, cyc);
        @(posedge Clk);
        #1;
        setReq(1'b1, 1'b0, 1'b0, '0, '0);
        toIdle();

        // 5: reset mid-ISSUE drops the strobe immediately, no done, tie goes to port 0
        issue(1'b0, 1'b1, 32'd9, 32'h999, 32'h0);
        check("t5_write_before_rst", 64'(bus.mem_write), 64'd1);
        #1;
        reset = 1'b1;
        expQ.delete();
        nAborted++;
        #1;
        check("t5_write_dropped", 64'(bus.mem_write), 64'd0);
        check("t5_read_dropped", 64'(bus.mem_read), 64'd0);
        @(negedge Clk);
        reset = 1'b0;
        doneBefore = nDone;
        repeat (4) @(negedge Clk);
        check("t5_no_done", 64'(nDone), 64'(doneBefore));
        setReq(1'b0, 1'b1, 1'b0, 32'd1, '0);
        setReq(1'b1, 1'b1, 1'b0, 32'd2, '0);
        #1;
        check("t5_tie_ready0", 64'(bus.req0_ready), 64'd1);
        check("t5_tie_ready1", 64'(bus.req1_ready), 64'd0);
        if (bus.req0_ready) pushExp(1'b0, 32'hA000_0001, cyc);
        @(posedge Clk);
        #1;
        setReq(1'b0, 1'b0, 1'b0, '0, '0);
        k = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            #1;
            if (bus.req1_ready) begin
                k = cyc;
                break;
            end
        end
        check("t5_port1_wait", 64'(k >= 0), 64'd1);
        if (k >= 0) pushExp(1'b1, 32'hA000_0002, k);
        @(posedge Clk);
        #1;
        setReq(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (4) @(posedge Clk);

        // 6: one done per accepted (non-aborted) request
        check("done_count", 64'(nDone), 64'(nAccepted - nAborted));
        check("queue_empty", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
